// File: rtl/alu_pkg.sv
// Types and constants shared by the issue stage and the ALU it feeds.
// The opcode enum lives here so both sides agree on the encoding.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100
  } alu_op_e;

  // Everything the EX register presents to the ALU in one cycle.
  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
  } ex_ops_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command, ALU and result signals of the issue stage.
// The stage uses the slave view; the command source, ALU and consumer use the master view.
interface alu_issue_stage_if #(
  parameter int NUM_REGS = 8
);
  import alu_pkg::*;

  localparam int REG_AW = $clog2(NUM_REGS);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_opcode;
  logic [REG_AW-1:0] cmd_rd;
  logic [REG_AW-1:0] cmd_rs1;
  logic [REG_AW-1:0] cmd_rs2;
  logic              cmd_use_imm;
  logic [DATA_W-1:0] cmd_imm;

  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [OP_W-1:0]   alu_opcode;
  logic [DATA_W-1:0] alu_result;

  logic              res_valid;
  logic              res_ready;
  logic [REG_AW-1:0] res_rd;
  logic [DATA_W-1:0] res_data;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
    output cmd_ready,
    output operand_a, operand_b, alu_opcode,
    input  alu_result,
    output res_valid, res_rd, res_data,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
    input  cmd_ready,
    input  operand_a, operand_b, alu_opcode,
    output alu_result,
    input  res_valid, res_rd, res_data,
    output res_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// NUM_REGS x DATA_W register file: two asynchronous read ports, one synchronous write port.
// r0 is a constant zero and has no storage.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_a,
  output logic [DATA_W-1:0]           rdata_a,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_b,
  output logic [DATA_W-1:0]           rdata_b
);

  localparam int REG_AW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_flat;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs_flat[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] reg_q;
        logic [DATA_W-1:0] reg_d;

        always_comb begin
          reg_d = reg_q;
          if (we && (waddr == REG_AW'(gi))) begin
            reg_d = wdata;
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            reg_q <= '0;
          end else begin
            reg_q <= reg_d;
          end
        end

        assign regs_flat[gi] = reg_q;
      end
    end
  endgenerate

  assign rdata_a = regs_flat[raddr_a];
  assign rdata_b = regs_flat[raddr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue stage: EX register feeding an external ALU, WB register retiring its result
// into the register file, with forwarding from both in-flight slots so dependent commands never bubble.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_stage_if.slave   bus
);

  localparam int REG_AW = $clog2(NUM_REGS);

  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  ex_ops_t           ex_ops_q, ex_ops_d;

  logic              res_valid_q, res_valid_d;
  logic [REG_AW-1:0] res_rd_q, res_rd_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;

  logic              stall;
  logic              rf_we;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;
  logic [DATA_W-1:0] src_a, src_b;

  assign stall = res_valid_q & ~bus.res_ready;
  assign rf_we = res_valid_q & bus.res_ready & (res_rd_q != '0);

  alu_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (res_rd_q),
    .wdata   (res_data_q),
    .raddr_a (bus.cmd_rs1),
    .rdata_a (rf_rdata_a),
    .raddr_b (bus.cmd_rs2),
    .rdata_b (rf_rdata_b)
  );

  // Youngest producer wins: EX (result still on the ALU) before WB before the register file.
  function automatic logic [DATA_W-1:0] pick_src(
    input logic [REG_AW-1:0] rs,
    input logic [DATA_W-1:0] rf_val,
    input logic              ex_vld,
    input logic [REG_AW-1:0] ex_rd,
    input logic [DATA_W-1:0] ex_val,
    input logic              wb_vld,
    input logic [REG_AW-1:0] wb_rd,
    input logic [DATA_W-1:0] wb_val
  );
    logic [DATA_W-1:0] val;
    if (rs == '0) begin
      val = '0;
    end else if (ex_vld && (ex_rd == rs)) begin
      val = ex_val;
    end else if (wb_vld && (wb_rd == rs)) begin
      val = wb_val;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  always_comb begin
    src_a = pick_src(bus.cmd_rs1, rf_rdata_a, ex_valid_q, ex_rd_q, bus.alu_result,
                     res_valid_q, res_rd_q, res_data_q);
    src_b = bus.cmd_use_imm ? bus.cmd_imm
                            : pick_src(bus.cmd_rs2, rf_rdata_b, ex_valid_q, ex_rd_q, bus.alu_result,
                                       res_valid_q, res_rd_q, res_data_q);
  end

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_rd_d     = ex_rd_q;
    ex_ops_d    = ex_ops_q;
    res_valid_d = res_valid_q;
    res_rd_d    = res_rd_q;
    res_data_d  = res_data_q;

    if (!stall) begin
      res_valid_d = ex_valid_q;
      res_rd_d    = ex_rd_q;
      res_data_d  = bus.alu_result;
      if (bus.cmd_valid) begin
        ex_valid_d      = 1'b1;
        ex_rd_d         = bus.cmd_rd;
        ex_ops_d.opcode = bus.cmd_opcode;
        ex_ops_d.opa    = src_a;
        ex_ops_d.opb    = src_b;
      end else begin
        // Bubble: operands stay put so the ALU inputs do not toggle needlessly.
        ex_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_ops_q    <= '0;
      res_valid_q <= 1'b0;
      res_rd_q    <= '0;
      res_data_q  <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_ops_q    <= ex_ops_d;
      res_valid_q <= res_valid_d;
      res_rd_q    <= res_rd_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.cmd_ready  = ~stall;
  assign bus.operand_a  = ex_ops_q.opa;
  assign bus.operand_b  = ex_ops_q.opb;
  assign bus.alu_opcode = ex_ops_q.opcode;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_rd     = res_rd_q;
  assign bus.res_data   = res_data_q;

endmodule
